// File: rtl/matmul_ctrl.sv
// rtl/matmul_ctrl.sv - sequencing controller for a 4x4 matrix multiply datapath
module matmul_ctrl #(
    parameter int DW         = 18,
    parameter int N_OUT      = 16,
    parameter int MUL_CYCLES = 2,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    output logic                  mul_en,
    output logic                  add_en,
    input  logic                  add_valid,
    input  logic [N_OUT*DW-1:0]   sum_in,
    output logic [DW-1:0]         res_data,
    output logic [3:0]            res_idx,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_ADD, S_SEND, S_DONE} state_t;

    localparam logic [7:0] MUL_LAST = 8'(MUL_CYCLES - 1);
    localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);
    localparam logic [3:0] IDX_LAST = 4'(N_OUT - 1);

    state_t        state;
    logic [7:0]    cnt;
    logic [DW-1:0] buffer [N_OUT];
    logic          capture;
    logic [3:0]    idx_next;

    assign capture  = (state == S_ADD) && add_valid && !abort;
    assign idx_next = res_idx + 4'd1;

    // Result buffer carries no reset; it is always written before SEND reads it.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int k = 0; k < N_OUT; k++) begin
                buffer[k] <= sum_in[k*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            mul_en    <= 1'b0;
            add_en    <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_idx   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else if (abort && state != S_IDLE) begin
            state     <= S_IDLE;
            cnt       <= '0;
            mul_en    <= 1'b0;
            add_en    <= 1'b0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state  <= S_MUL;
                        cnt    <= '0;
                        mul_en <= 1'b1;
                        busy   <= 1'b1;
                        err    <= 1'b0;
                    end
                end
                S_MUL: begin
                    if (cnt == MUL_LAST) begin
                        state  <= S_ADD;
                        cnt    <= '0;
                        add_en <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_ADD: begin
                    // A valid sum on the final timeout cycle still wins over the error.
                    if (add_valid) begin
                        state     <= S_SEND;
                        mul_en    <= 1'b0;
                        add_en    <= 1'b0;
                        res_valid <= 1'b1;
                        res_data  <= sum_in[DW-1:0];
                        res_idx   <= '0;
                    end else if (cnt == TO_LAST) begin
                        state  <= S_DONE;
                        mul_en <= 1'b0;
                        add_en <= 1'b0;
                        done   <= 1'b1;
                        err    <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_SEND: begin
                    if (res_ready) begin
                        if (res_idx == IDX_LAST) begin
                            state     <= S_DONE;
                            res_valid <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            res_idx  <= idx_next;
                            res_data <= buffer[idx_next];
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/matmul_ctrl.md
MATMUL_CTRL -- requirements
Module: matmul_ctrl

Interface
REQ-001 Parameter DW, default 18, width of one result element.
REQ-002 Parameter N_OUT, default 16, result elements per operation (4x4 matrix).
REQ-003 Parameter MUL_CYCLES, default 2, cycles the multiply stage is enabled before summation starts; legal range 1..15.
REQ-004 Parameter TIMEOUT, default 15, maximum cycles in ADD awaiting add_valid; legal range 1..255.
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  request one matrix operation; sampled only in IDLE.
REQ-008 abort  input  1  synchronous cancel of the operation in progress.
REQ-009 mul_en  output  1  enable to the multiply stage.
REQ-010 add_en  output  1  enable to the summing datapath; doubles as its active-low clear when 0.
REQ-011 add_valid  input  1  summing datapath reports sum_in valid.
REQ-012 sum_in  input  N_OUT*DW  packed sums, element k at bits [k*DW +: DW].
REQ-013 res_data  output  DW  current result element.
REQ-014 res_idx  output  4  index (0..N_OUT-1) of res_data.
REQ-015 res_valid  output  1  res_data/res_idx valid.
REQ-016 res_ready  input  1  consumer accepts the element when high with res_valid.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 done  output  1  one-cycle pulse when an operation ends.
REQ-019 err  output  1  timeout flag, qualified by done.

Function
REQ-020 FSM states: IDLE, MUL, ADD, SEND, DONE.
REQ-021 IDLE: start=1 -> MUL, MUL counter cleared; start ignored in all other states.
REQ-022 MUL: mul_en=1 for exactly MUL_CYCLES cycles, then -> ADD; mul_en stays 1 in ADD.
REQ-023 ADD: add_en=1 every cycle; first cycle with add_valid=1 captures all N_OUT elements of sum_in into an internal buffer and -> SEND, element index cleared to 0.
REQ-024 ADD timeout: counter increments each ADD cycle without add_valid; reaching TIMEOUT -> DONE with err=1; add_valid in the same cycle the counter reaches TIMEOUT takes priority (capture, no error).
REQ-025 mul_en and add_en SHALL both be 0 in IDLE, SEND and DONE; leaving ADD therefore clears the summing datapath.
REQ-026 SEND: res_valid=1, res_data=buffer[idx], res_idx=idx; outputs SHALL hold stable while res_ready=0.
REQ-027 SEND: res_valid&res_ready advances idx by 1; acceptance at idx=N_OUT-1 -> DONE, res_valid=0 next cycle.
REQ-028 DONE: done=1 for one cycle, err=1 only for timeout termination, -> IDLE; err held until next start.
REQ-029 abort=1 in any non-IDLE state -> IDLE next cycle, enables and res_valid drop, no done pulse, buffer contents undefined; abort in IDLE has no effect; abort wins over every simultaneous transition.
REQ-030 Buffer data is unsigned, passed unmodified; no arithmetic in this block.
REQ-031 Latency: start sampled at cycle 0 -> mul_en cycles 1..MUL_CYCLES+ADD, add_en from cycle MUL_CYCLES+1; first res_valid one cycle after add_valid sampled.
REQ-032 Buffer elements beyond N_OUT-1 do not exist; res_idx never exceeds N_OUT-1.

Reset
REQ-033 reset=1 asynchronously forces IDLE; mul_en, add_en, res_valid, busy, done, err=0; res_data, res_idx=0; counters and idx=0.
REQ-034 reset deasserted with start=1 in the same cycle SHALL be sampled normally on the next rising edge.
REQ-035 Buffer contents need not be reset.

Verification
REQ-036 Nominal: MUL_CYCLES=2, start at cycle 0, add_valid at cycle 4 with element k = k+100, res_ready=1 -> res_data 100..115 on cycles 5..20, idx 0..15, done at 21, err=0.
REQ-037 Backpressure: res_ready=0 for 3 cycles at idx=5 -> res_data=105 and res_idx=5 held, no element skipped or duplicated, 16 total accepted.
REQ-038 Timeout: add_valid never asserted, TIMEOUT=15 -> add_en high 15 cycles, then done=1 with err=1, no res_valid ever.
REQ-039 Abort: abort during SEND at idx=7 -> IDLE next cycle, res_valid=0, no done; fresh start completes normally with err=0.
REQ-040 Reset mid-ADD: reset asserted asynchronously between edges -> all outputs 0 immediately; start while busy (cycle 3) ignored, single done only.
